jtopl_wrq: RTL and testbench
============================

// Module: jtopl_wrq
// PURPOSE
// - Parametrised CPU-to-OPL register write queue with timing pacing; sits between the host bus and a jtopl core.
// - Host writes land in a FIFO without stalls.
// - The drain FSM replays each write to the core and enforces the OPL post-address and post-data wait times.
// - Supports single-bank (OPL2) and dual-bank (OPL3-style) address maps.
// PARAMETERS
// - DEPTH   16  FIFO entries; power of two, 4..256
// - ADDR_W  1   host address width; 1 = OPL2 (A0), 2 = dual bank (A1 bank, A0 addr/data)
// - AWAIT   12  cen ticks the drain waits after an address-port write
// - DWAIT   84  cen ticks the drain waits after a data-port write
// - STB_LEN 2   cen ticks opl_cs_n/opl_wr_n are held low per replayed write
// PORTS
// - clk       in   1         system clock
// - rst_n     in   1         synchronous reset, active low
// - cen       in   1         clock enable shared with the core; all pacing counts cen ticks
// - din       in   8         host write data
// - addr      in   ADDR_W    host address
// - cs_n      in   1         host chip select, active low
// - wr_n      in   1         host write strobe, active low
// - flush     in   1         discard queued entries (1-clk pulse)
// - clr_ovf   in   1         clear the overflow flag
// - level     out  clog2(DEPTH)+1  current entry count
// - full      out  1         level==DEPTH
// - empty     out  1         level==0
// - ovf       out  1         sticky flag: a write was dropped
// - busy      out  1         FSM not IDLE, or !empty
// - opl_din   out  8         data to the core
// - opl_addr  out  ADDR_W    address to the core
// - opl_cs_n  out  1         core chip select
// - opl_wr_n  out  1         core write strobe
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): level=0, full=0, empty=1, ovf=0, busy=0, opl_cs_n=1, opl_wr_n=1, opl_din=0, opl_addr=0, FSM=IDLE.
//   - Reset mid-strobe aborts the strobe immediately.
// - Push:
//   - Trigger: one push per host write, on the rising edge of wr = !cs_n & !wr_n, detected against wr registered at clk (not gated by cen).
//   - A held strobe pushes once.
//   - Entry = {addr, din} sampled in the cycle the edge is detected.
// - Full:
//   - A push with level==DEPTH and no same-cycle pop is dropped and sets ovf.
//   - A push and pop in the same cycle with level==DEPTH is accepted; level is unchanged.
// - ovf: clr_ovf clears it. Set wins if set and clear occur in the same cycle.
// - flush:
//   - Sets level to 0 next cycle.
//   - A push in the flush cycle is discarded and does not set ovf.
//   - An in-progress STROBE/WAIT completes normally.
// - FSM (advances only when cen=1, except reset):
//   - IDLE:
//     - If !empty: pop the head, drive opl_din/opl_addr, go to STROBE.
//     - In the same cen tick, opl_cs_n=0 and opl_wr_n=0.
//   - STROBE:
//     - Hold the strobe for STB_LEN cen ticks; opl_din/opl_addr are stable throughout.
//     - Then deassert opl_cs_n/opl_wr_n and go to WAIT.
//     - Load cnt = addr[0] ? DWAIT : AWAIT.
//   - WAIT:
//     - Decrement cnt per cen tick.
//     - At cnt==1: go to IDLE, so the next strobe can start on the following tick.
//   - Back-to-back spacing (first strobe tick to next first strobe tick):
//     - STB_LEN+AWAIT+1 cen ticks after an address write.
//     - STB_LEN+DWAIT+1 cen ticks after a data write.
// - Width/arith:
//   - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
//   - level is one bit wider than the pointers.
//   - cnt is clog2(max(AWAIT,DWAIT))+1 bits.
// - Ordering is strictly FIFO; bank bits pass through unchanged.
// STRUCTURE
// - jtopl_wrq.vh: FSM state encodings (IDLE/STROBE/WAIT) and default timing constants, shared with the bench.
// - Sub-module jtopl_wrq_fifo: DEPTH x (ADDR_W+8) sync FIFO with push, pop, flush, level, full and empty.
//   - Memory is a register array.
//   - Pop data is valid in the same cycle as the pop (show-ahead).
// - Top level: edge detector, ovf logic, pacing FSM and counter.
// TESTING
// - Reset, then idle 20 cen ticks -> opl_cs_n=1, empty=1, level=0, ovf=0, busy=0.
// - Write addr=0 din=0x20, then addr=1 din=0x01 (OPL2) -> core sees the first strobe, then the second strobe exactly STB_LEN+AWAIT+1 = 15 cen ticks later with opl_din=0x01.
// - DEPTH=16, cen held low, 17 writes -> level=16, full=1, ovf=1, 17th entry absent. Then cen=1 -> 16 strobes in order, spaced per the rules above.
// - Write held low for 10 clk -> exactly one push, level=1.
// - Queue 5 entries, pulse flush during a WAIT -> current WAIT completes, no further strobes, empty=1, ovf unchanged.
// - ADDR_W=2, write addr=2'b10 din=0x05 -> opl_addr=2'b10, opl_din=0x05. Following spacing is AWAIT-based (12 ticks wait).

Source files
------------

// File: rtl/jtopl_wrq_pkg.sv
// jtopl_wrq_pkg: shared definitions for the OPL register write queue.
//   - wrq_state_e : drain FSM state encoding (IDLE / STROBE / WAIT)
//   - DEF_*       : default queue depth and OPL pacing constants (cen ticks)
//   - max2        : helper used to size the wait counter
package jtopl_wrq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2
    } wrq_state_e;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_AWAIT   = 12;
    localparam int DEF_DWAIT   = 84;
    localparam int DEF_STB_LEN = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jtopl_wrq_fifo.sv
// jtopl_wrq_fifo: DEPTH x W synchronous show-ahead FIFO backed by a register array.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write wdata (ignored when full unless a pop happens in the same cycle)
//   pop        : consume the head; rdata already shows the head before the pop
//   flush      : empty the FIFO next cycle; a push in the same cycle is discarded
//   wdata      : entry to write
//   rdata      : head entry (valid while !empty)
//   level      : entry count, one bit wider than the pointers
//   full/empty : level==DEPTH / level==0
module jtopl_wrq_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_LVL);
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/jtopl_wrq.sv
// jtopl_wrq: host-to-OPL register write queue with OPL write pacing.
// Host writes are captured into a FIFO without stalling; a drain FSM replays
// them to the core, holding the strobe STB_LEN cen ticks and then waiting
// AWAIT (address port, A0=0) or DWAIT (data port, A0=1) cen ticks.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   cen                 : clock enable shared with the core; all pacing counts cen ticks
//   din, addr           : host write data / address ({bank, A0} when ADDR_W=2)
//   cs_n, wr_n          : host chip select / write strobe, active low
//   flush               : drop every queued entry (in-flight write still completes)
//   clr_ovf             : clear the sticky overflow flag
//   level, full, empty  : queue occupancy
//   ovf                 : sticky, a host write was dropped on a full queue
//   busy                : drain FSM active or queue not empty
//   opl_din, opl_addr   : replayed write to the core
//   opl_cs_n, opl_wr_n  : core strobes, active low
//
// Host handshake: there is no ready. Each rising edge of (!cs_n & !wr_n),
// seen at clk, is one write request and {addr, din} of that cycle is the
// payload; a request that finds the queue full (and no same-cycle drain)
// is dropped and reported through ovf.
module jtopl_wrq
    import jtopl_wrq_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = 1,
    parameter int AWAIT   = DEF_AWAIT,
    parameter int DWAIT   = DEF_DWAIT,
    parameter int STB_LEN = DEF_STB_LEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cen,
    input  logic [7:0]              din,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    cs_n,
    input  logic                    wr_n,
    input  logic                    flush,
    input  logic                    clr_ovf,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic                    ovf,
    output logic                    busy,
    output logic [7:0]              opl_din,
    output logic [ADDR_W-1:0]       opl_addr,
    output logic                    opl_cs_n,
    output logic                    opl_wr_n
);
    localparam int W  = ADDR_W + 8;
    localparam int CW = $clog2(max2(AWAIT, DWAIT)) + 1;
    localparam int SW = $clog2(STB_LEN) + 1;

    localparam logic [CW-1:0] AWAIT_C = CW'(AWAIT);
    localparam logic [CW-1:0] DWAIT_C = CW'(DWAIT);
    localparam logic [SW-1:0] STB_C   = SW'(STB_LEN);

    wrq_state_e    state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stb_cnt;

    logic          wr_req;
    logic          wr_q;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic [W-1:0]  head;

    // Edge detector runs on every clk so short host strobes are never missed.
    assign wr_req = ~cs_n & ~wr_n;
    assign push   = wr_req & ~wr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) wr_q <= 1'b0;
        else        wr_q <= wr_req;
    end

    // Popping is held off during a flush so the flush really empties the queue.
    assign pop = (state == ST_IDLE) & cen & ~empty & ~flush;

    jtopl_wrq_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push & ~flush),
        .pop   (pop),
        .flush (flush),
        .wdata ({addr, din}),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // A flushed push is discarded silently, it is not an overflow.
    assign ovf_set = push & ~flush & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst_n)       ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end

    assign busy = (state != ST_IDLE) | ~empty;

    // Timeline per replayed write (cen ticks): strobe goes low at tick T,
    // back high at T+STB_LEN, IDLE again at T+STB_LEN+wait, next strobe at
    // T+STB_LEN+wait+1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            opl_din  <= 8'd0;
            opl_addr <= '0;
            cnt      <= '0;
            stb_cnt  <= '0;
        end else if (cen) begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {opl_addr, opl_din} <= head;
                        opl_cs_n <= 1'b0;
                        opl_wr_n <= 1'b0;
                        stb_cnt  <= STB_C;
                        state    <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (stb_cnt == SW'(1)) begin
                        opl_cs_n <= 1'b1;
                        opl_wr_n <= 1'b1;
                        cnt      <= opl_addr[0] ? DWAIT_C : AWAIT_C;
                        state    <= ST_WAIT;
                    end else begin
                        stb_cnt <= stb_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == CW'(1)) state <= ST_IDLE;
                    else               cnt   <= cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtopl_wrq.sv
// tb_jtopl_wrq: bench for jtopl_wrq (DEPTH=16, dual-bank map, OPL timing).
// A timeline model (queue of entries plus start tick of the write in
// flight) predicts every output on every clock; directed tests pin the
// model with literal spacings and counts.
module tb_jtopl_wrq;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 2;
    localparam int AWAIT   = 12;
    localparam int DWAIT   = 84;
    localparam int STB_LEN = 2;
    localparam int W       = ADDR_W + 8;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cen = 1'b0;
    logic [7:0]        din = 8'd0;
    logic [ADDR_W-1:0] addr = '0;
    logic              cs_n = 1'b1;
    logic              wr_n = 1'b1;
    logic              flush = 1'b0;
    logic              clr_ovf = 1'b0;
    logic [LW-1:0]     level;
    logic              full, empty, ovf, busy;
    logic [7:0]        opl_din;
    logic [ADDR_W-1:0] opl_addr;
    logic              opl_cs_n, opl_wr_n;

    jtopl_wrq #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AWAIT(AWAIT), .DWAIT(DWAIT), .STB_LEN(STB_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(din), .addr(addr),
        .cs_n(cs_n), .wr_n(wr_n), .flush(flush), .clr_ovf(clr_ovf),
        .level(level), .full(full), .empty(empty), .ovf(ovf), .busy(busy),
        .opl_din(opl_din), .opl_addr(opl_addr), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n)
    );

    // ---------------- clock / reset / cen ----------------
    always #5 clk = ~clk;

    int cen_mode = 0;  // 0: always on, 1: random, 2: held low
    always @(negedge clk) begin
        case (cen_mode)
            0:       cen = 1'b1;
            1:       cen = ($urandom_range(0, 1) == 1);
            default: cen = 1'b0;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model + compare + strobe monitor ----------------
    logic [W-1:0] exp_q[$];
    bit           m_wr_prev, m_ovf, m_inflight, m_push, m_pop, m_ovf_set, m_free, m_wr;
    longint       m_n, m_n0;
    int           m_wait, m_s;
    logic [W-1:0] m_cur;
    bit           e_strobe, e_busy;

    int           mon_ticks = 0;
    bit           mon_prev_cs = 1'b1;
    int           fall_q[$];
    logic [W-1:0] fall_ent[$];

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_wr_prev = 0; m_ovf = 0; m_inflight = 0;
                m_n = 0; m_n0 = 0; m_wait = 0; m_cur = '0;
            end else begin
                m_wr      = !cs_n && !wr_n;
                m_push    = m_wr && !m_wr_prev;
                m_wr_prev = m_wr;
                m_s       = exp_q.size();
                m_pop     = 0;
                m_ovf_set = 0;
                if (cen === 1'b1) begin
                    m_n++;
                    m_free = !m_inflight || (m_n >= m_n0 + STB_LEN + m_wait + 1);
                    if (m_free && m_s > 0 && !flush) begin
                        m_cur      = exp_q.pop_front();
                        m_n0       = m_n;
                        m_inflight = 1;
                        m_wait     = m_cur[8] ? DWAIT : AWAIT;
                        m_pop      = 1;
                    end
                end
                if (flush) exp_q.delete();
                else if (m_push) begin
                    if (m_s < DEPTH || m_pop) exp_q.push_back({addr, din});
                    else                      m_ovf_set = 1;
                end
                if (m_ovf_set)    m_ovf = 1;
                else if (clr_ovf) m_ovf = 0;
            end
            if (cen === 1'b1) mon_ticks++;
            #1;
            e_strobe = m_inflight && (m_n - m_n0 < STB_LEN);
            e_busy   = (exp_q.size() != 0) || (m_inflight && (m_n < m_n0 + STB_LEN + m_wait));
            chk("level",    level,    exp_q.size());
            chk("full",     full,     exp_q.size() == DEPTH);
            chk("empty",    empty,    exp_q.size() == 0);
            chk("ovf",      ovf,      m_ovf);
            chk("busy",     busy,     e_busy);
            chk("opl_cs_n", opl_cs_n, !e_strobe);
            chk("opl_wr_n", opl_wr_n, !e_strobe);
            chk("opl_din",  opl_din,  m_cur[7:0]);
            chk("opl_addr", opl_addr, m_cur[W-1:8]);
            if (opl_cs_n === 1'b0 && mon_prev_cs) begin
                fall_q.push_back(mon_ticks);
                fall_ent.push_back({opl_addr, opl_din});
            end
            mon_prev_cs = (opl_cs_n !== 1'b0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, input int hold);
        @(negedge clk);
        addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
        repeat (hold) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k = 0;
        while ((busy !== 1'b0 || opl_cs_n !== 1'b1) && k < bound) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= bound) begin
            n_errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, bound);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; flush = 1'b0; clr_ovf = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b;
        int k;
        bit seen_low;
        logic [W-1:0] ent [17];

        cen_mode = 0;
        do_reset(3);

        // Reset then idle 20 cen ticks.
        idle(20);
        chk("rst_cs_n",  opl_cs_n, 1'b1);
        chk("rst_empty", empty,    1'b1);
        chk("rst_level", level,    0);
        chk("rst_ovf",   ovf,      1'b0);
        chk("rst_busy",  busy,     1'b0);

        // Address write then data write: second strobe 15 cen ticks later.
        b = fall_q.size();
        host_write(2'b00, 8'h20, 1);
        idle(1);
        host_write(2'b01, 8'h01, 1);
        wait_idle("t2_idle", 1000);
        chk("t2_nstrobes", fall_q.size() - b, 2);
        if (fall_q.size() - b == 2) begin
            chk("t2_spacing", fall_q[b+1] - fall_q[b], 15);
            chk("t2_first",   fall_ent[b],   {2'b00, 8'h20});
            chk("t2_second",  fall_ent[b+1], {2'b01, 8'h01});
        end
        chk("t2_din_hold", opl_din, 8'h01);

        // cen low, 17 writes: 16 kept, 17th dropped with ovf.
        cen_mode = 2;
        for (int i = 0; i < 17; i++) begin
            ent[i] = W'($urandom_range(0, (1 << W) - 1));
            host_write(ent[i][W-1:8], ent[i][7:0], 1);
        end
        idle(2);
        chk("t3_level", level, 16);
        chk("t3_full",  full,  1'b1);
        chk("t3_ovf",   ovf,   1'b1);
        b = fall_q.size();
        cen_mode = 1;
        wait_idle("t3_idle", 20000);
        chk("t3_nstrobes", fall_q.size() - b, 16);
        if (fall_q.size() - b == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk("t3_order", fall_ent[b+i], ent[i]);
                if (i < 15)
                    chk("t3_spacing", fall_q[b+i+1] - fall_q[b+i],
                        STB_LEN + (ent[i][8] ? DWAIT : AWAIT) + 1);
            end
        end
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        chk("t3_ovf_clr", ovf, 1'b0);

        // Held write for 10 clocks pushes once.
        cen_mode = 2;
        host_write(2'b00, 8'h44, 10);
        idle(2);
        chk("t4_level", level, 1);
        cen_mode = 0;
        wait_idle("t4_idle", 1000);

        // Flush during WAIT: in-flight write completes, rest are dropped.
        cen_mode = 2;
        host_write(2'b01, 8'hA0, 1);
        for (int i = 1; i < 5; i++) host_write(2'b00, 8'(8'hA0 + i), 1);
        b = fall_q.size();
        cen_mode = 0;
        seen_low = 0;
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (!seen_low && opl_cs_n === 1'b0) seen_low = 1;
            else if (seen_low && opl_cs_n === 1'b1) break;
        end
        n_checks++;
        if (k >= 400) begin
            n_errors++;
            $display("FAIL t5_strobe_end: strobe did not complete within %0d cycles, expected one", k);
        end
        idle(5);
        @(negedge clk);
        flush = 1'b1; addr = 2'b01; din = 8'hEE; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        flush = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
        chk("t5_busy_after_flush", busy, 1'b1);
        wait_idle("t5_idle", 1000);
        chk("t5_nstrobes", fall_q.size() - b, 1);
        chk("t5_empty", empty, 1'b1);
        chk("t5_level", level, 0);
        chk("t5_ovf",   ovf,   1'b0);

        // Bank bit passes through; spacing still follows A0.
        b = fall_q.size();
        host_write(2'b10, 8'h05, 1);
        idle(1);
        host_write(2'b00, 8'h07, 1);
        wait_idle("t6_idle", 1000);
        chk("t6_nstrobes", fall_q.size() - b, 2);
        if (fall_q.size() - b == 2) begin
            chk("t6_first",   fall_ent[b], {2'b10, 8'h05});
            chk("t6_spacing", fall_q[b+1] - fall_q[b], STB_LEN + AWAIT + 1);
        end

        // Random traffic: overflows, flushes, clears, one mid-run reset.
        cen_mode = 1;
        for (int i = 0; i < 90; i++) begin
            k = $urandom_range(0, 29);
            if (i == 45) begin
                do_reset(2);
            end else if (k == 0) begin
                @(negedge clk); flush = 1'b1;
                @(negedge clk); flush = 1'b0;
            end else if (k == 1) begin
                @(negedge clk); clr_ovf = 1'b1;
                @(negedge clk); clr_ovf = 1'b0;
            end else begin
                host_write(ADDR_W'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                           $urandom_range(1, 3));
            end
            idle($urandom_range(0, 6));
        end
        wait_idle("rand_idle", 30000);
        chk("rand_empty", empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
